// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state and owner types for the fetch/data memory arbiter
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner select; MEM_ARB_RR_EN selects round-robin over data-first priority
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  arb_owner_t last_served,
  output logic       grant_if,
  output logic       grant_d
);

`ifdef MEM_ARB_RR_EN
  // On a tie the side not served last goes next; a lone request always wins.
  always_comb begin
    grant_if = if_req;
    grant_d  = d_req;
    if (if_req && d_req) begin
      grant_if = (last_served == OWN_D);
      grant_d  = (last_served == OWN_IF);
    end
  end
`else
  logic unused_last_served;

  assign unused_last_served = (last_served == OWN_D);
  assign grant_d            = d_req;
  assign grant_if           = if_req & ~d_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory shared by fetch and data ports, one access in flight
// Arbitration policy is chosen in arb_pick via MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  output logic            stall
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);

  arb_state_t       state;
  arb_owner_t       owner;
  arb_owner_t       last_served;
  logic [CNT_W-1:0] counter;

  logic resp_cycle;
  logic grant_phase;
  logic pick_if;
  logic pick_d;
  logic grant_if;
  logic grant_d;

  arb_pick u_pick (
    .if_req      (if_req),
    .d_req       (d_req),
    .last_served (last_served),
    .grant_if    (pick_if),
    .grant_d     (pick_d)
  );

  // A new grant may overlap the response cycle, giving one access per MEM_LAT cycles.
  assign resp_cycle  = (state == ARB_BUSY) && (counter == CNT_ONE);
  assign grant_phase = reset_n && ((state == ARB_IDLE) || resp_cycle);
  assign grant_if    = grant_phase & pick_if;
  assign grant_d     = grant_phase & pick_d;

  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign if_rvalid = resp_cycle && (owner == OWN_IF);
  assign d_rvalid  = resp_cycle && (owner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (grant_d) begin
      mem_req   = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else if (grant_if) begin
      mem_req  = 1'b1;
      mem_addr = if_addr;
      mem_be   = '1;
    end
  end

  assign stall = reset_n &
                 ((if_req & ~if_rvalid) |
                  (d_req & ~d_gnt) |
                  ((owner == OWN_D) & (state == ARB_BUSY) & ~d_rvalid));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ARB_IDLE;
      owner       <= OWN_IF;
      counter     <= '0;
      last_served <= OWN_D;
    end else if (grant_if || grant_d) begin
      state       <= ARB_BUSY;
      counter     <= CNT_LOAD;
      owner       <= grant_d ? OWN_D : OWN_IF;
      last_served <= grant_d ? OWN_D : OWN_IF;
    end else if (resp_cycle) begin
      state   <= ARB_IDLE;
      counter <= '0;
    end else if (state == ARB_BUSY) begin
      counter <= counter - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter at MEM_LAT=1 (dut_a) and MEM_LAT=3 (dut_b); honours MEM_ARB_RR_EN
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        a_if_req, a_d_req, a_d_we;
  logic [31:0] a_if_addr, a_d_addr, a_d_wdata, a_mem_rdata;
  logic [3:0]  a_d_be;
  logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_req, a_mem_we, a_stall;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;

  logic        b_if_req, b_d_req, b_d_we;
  logic [31:0] b_if_addr, b_d_addr, b_d_wdata, b_mem_rdata;
  logic [3:0]  b_d_be;
  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_req, b_mem_we, b_stall;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_be;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_be(a_d_be), .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_be(a_mem_be), .mem_rdata(a_mem_rdata),
    .stall(a_stall)
  );

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_be(b_d_be), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_be(b_mem_be), .mem_rdata(b_mem_rdata),
    .stall(b_stall)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    next_cycle();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    a_if_req = 1'b0; a_d_req = 1'b0; a_d_we = 1'b0; a_d_be = 4'h0;
    a_if_addr = '0; a_d_addr = '0; a_d_wdata = '0; a_mem_rdata = '0;
    b_if_req = 1'b0; b_d_req = 1'b0; b_d_we = 1'b0; b_d_be = 4'h0;
    b_if_addr = '0; b_d_addr = '0; b_d_wdata = '0; b_mem_rdata = '0;

    // Reset held with a pending fetch: everything quiet.
    a_if_req = 1'b1; a_if_addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    chk("rst_if_gnt", a_if_gnt, 0);
    chk("rst_mem_req", a_mem_req, 0);
    chk("rst_mem_addr", a_mem_addr, 0);
    chk("rst_stall", a_stall, 0);
    chk("rst_if_rvalid", a_if_rvalid, 0);
    chk("rst_b_mem_req", b_mem_req, 0);

    // Release: fetch granted at once, data back one cycle later.
    next_cycle();
    reset_n = 1'b1;
    a_mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("if_gnt_T", a_if_gnt, 1);
    chk("if_mem_req_T", a_mem_req, 1);
    chk("if_mem_addr_T", a_mem_addr, 32'h10);
    chk("if_mem_we_T", a_mem_we, 0);
    chk("if_mem_be_T", a_mem_be, 4'hF);
    chk("if_stall_T", a_stall, 1);
    chk("if_d_gnt_T", a_d_gnt, 0);
    next_cycle();
    a_if_req = 1'b0;
    @(negedge clk);
    chk("if_rvalid_T1", a_if_rvalid, 1);
    chk("if_rdata_T1", a_if_rdata, 32'hDEADBEEF);
    chk("if_d_rvalid_T1", a_d_rvalid, 0);
    chk("if_mem_req_T1", a_mem_req, 0);
    chk("if_stall_T1", a_stall, 0);
    next_cycle();
    @(negedge clk);
    chk("if_rvalid_T2", a_if_rvalid, 0);
    chk("if_rdata_T2", a_if_rdata, 0);

    // Simultaneous requests from reset (last_served = data).
    reset_pulse();
    a_if_req = 1'b1; a_if_addr = 32'h20;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h30; a_d_be = 4'hF;
    a_mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("sim_d_gnt_c0", a_d_gnt, !RR);
    chk("sim_if_gnt_c0", a_if_gnt, RR);
    chk("sim_addr_c0", a_mem_addr, RR ? 32'h20 : 32'h30);
    chk("sim_stall_c0", a_stall, 1);
    next_cycle();
    if (RR) a_if_req = 1'b0;
    else    a_d_req  = 1'b0;
    @(negedge clk);
    chk("sim_if_rvalid_c1", a_if_rvalid, RR);
    chk("sim_d_rvalid_c1", a_d_rvalid, !RR);
    chk("sim_if_gnt_c1", a_if_gnt, !RR);
    chk("sim_d_gnt_c1", a_d_gnt, RR);
    chk("sim_addr_c1", a_mem_addr, RR ? 32'h30 : 32'h20);
    chk("sim_rdata_c1", RR ? a_if_rdata : a_d_rdata, 32'hCAFEF00D);
    chk("sim_stall_c1", a_stall, !RR);
    next_cycle();
    a_if_req = 1'b0;
    a_d_req  = 1'b0;
    @(negedge clk);
    chk("sim_if_rvalid_c2", a_if_rvalid, !RR);
    chk("sim_d_rvalid_c2", a_d_rvalid, RR);
    chk("sim_stall_c2", a_stall, 0);
    chk("sim_mem_req_c2", a_mem_req, 0);
    next_cycle();
    @(negedge clk);
    chk("sim_idle_if_rvalid", a_if_rvalid, 0);
    chk("sim_idle_d_rvalid", a_d_rvalid, 0);

    // Both held: data every time (fixed) or alternating IF, D (round-robin).
    reset_pulse();
    a_if_req = 1'b1;
    a_d_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("held_d_gnt_%0d", i), a_d_gnt, RR ? (i % 2 == 1) : 1'b1);
      chk($sformatf("held_if_gnt_%0d", i), a_if_gnt, RR ? (i % 2 == 0) : 1'b0);
      next_cycle();
    end
    a_if_req = 1'b0;
    a_d_req  = 1'b0;
    next_cycle();

    // MEM_LAT=3 store; a fetch arriving mid-flight waits for the response cycle.
    b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = 32'h40; b_d_wdata = 32'h1234; b_d_be = 4'hF;
    @(negedge clk);
    chk("st_d_gnt_T", b_d_gnt, 1);
    chk("st_mem_we_T", b_mem_we, 1);
    chk("st_mem_addr_T", b_mem_addr, 32'h40);
    chk("st_mem_wdata_T", b_mem_wdata, 32'h1234);
    chk("st_mem_be_T", b_mem_be, 4'hF);
    next_cycle();
    b_d_req = 1'b0; b_d_we = 1'b0;
    b_if_req = 1'b1; b_if_addr = 32'h50;
    b_mem_rdata = 32'h5555AAAA;
    @(negedge clk);
    chk("st_if_gnt_T1", b_if_gnt, 0);
    chk("st_mem_req_T1", b_mem_req, 0);
    chk("st_d_rvalid_T1", b_d_rvalid, 0);
    chk("st_stall_T1", b_stall, 1);
    next_cycle();
    @(negedge clk);
    chk("st_if_gnt_T2", b_if_gnt, 0);
    chk("st_d_rvalid_T2", b_d_rvalid, 0);
    next_cycle();
    @(negedge clk);
    chk("st_d_rvalid_T3", b_d_rvalid, 1);
    chk("st_if_gnt_T3", b_if_gnt, 1);
    chk("st_mem_addr_T3", b_mem_addr, 32'h50);
    chk("st_mem_we_T3", b_mem_we, 0);
    next_cycle();
    b_if_req = 1'b0;
    @(negedge clk);
    chk("st_if_rvalid_T4", b_if_rvalid, 0);
    next_cycle();
    @(negedge clk);
    chk("st_if_rvalid_T5", b_if_rvalid, 0);
    next_cycle();
    @(negedge clk);
    chk("st_if_rvalid_T6", b_if_rvalid, 1);
    chk("st_if_rdata_T6", b_if_rdata, 32'h5555AAAA);

    // Reset during a MEM_LAT=3 load discards the response.
    next_cycle();
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h60;
    @(negedge clk);
    chk("rm_d_gnt_T", b_d_gnt, 1);
    next_cycle();
    b_d_req = 1'b0;
    reset_n = 1'b0;
    #2;
    chk("rm_mem_req_inrst", b_mem_req, 0);
    chk("rm_stall_inrst", b_stall, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rm_d_rvalid_T1", b_d_rvalid, 0);
    next_cycle();
    @(negedge clk);
    chk("rm_d_rvalid_T2", b_d_rvalid, 0);
    next_cycle();
    @(negedge clk);
    chk("rm_d_rvalid_T3", b_d_rvalid, 0);
    chk("rm_stall_T3", b_stall, 0);
    next_cycle();
    b_d_req = 1'b1; b_d_addr = 32'h64;
    b_mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    chk("rm_regnt", b_d_gnt, 1);
    chk("rm_regnt_addr", b_mem_addr, 32'h64);
    next_cycle();
    b_d_req = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rm_re_d_rvalid", b_d_rvalid, 1);
    chk("rm_re_d_rdata", b_d_rdata, 32'h0BADF00D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
